// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: reset PC, PC step,
// redirect-source encoding and the PC sequencer FSM states.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_BR,
    SRC_J,
    SRC_JR
  } src_e;

  typedef enum logic {
    BOOT,
    RUN
  } state_e;

endpackage

// File: rtl/pc_target_sel.sv
// Redirect-source priority encoder (jr > jump > branch) and branch-target adder.
module pc_target_sel
  import cpu_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        branch_en,
  input  logic [15:0] branch_offset,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output src_e        src,
  output logic [31:0] target,
  output logic        misalign
);

  logic [31:0] branch_target;

  // Word offset sign-extended and scaled; the sum wraps mod 2^32.
  assign branch_target = pc + PC_STEP + {{14{branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    src      = SRC_SEQ;
    target   = '0;
    misalign = 1'b0;
    if (jr_en) begin
      src      = SRC_JR;
      target   = {jr_addr[31:2], 2'b00};
      misalign = (jr_addr[1:0] != 2'b00);
    end else if (jump_en) begin
      src    = SRC_J;
      target = jump_target;
    end else if (branch_en) begin
      src    = SRC_BR;
      target = branch_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register with fetch handshake, stall hold and a
// one-entry pending-redirect buffer for redirects seen while not advancing.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_ready,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [15:0] branch_offset,
  input  logic        jump_en,
  input  logic [31:0] jump_target,
  input  logic        jr_en,
  input  logic [31:0] jr_addr,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic [31:0] pc_plus4,
  output logic        misalign
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] pend_t_q, pend_t_d;
  logic        misalign_q;

  src_e        sel_src;
  logic [31:0] sel_target;
  logic        sel_misalign;
  logic        adv;
  logic        redirect;

  pc_target_sel u_target_sel (
    .pc            (pc_q),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .jr_en         (jr_en),
    .jr_addr       (jr_addr),
    .src           (sel_src),
    .target        (sel_target),
    .misalign      (sel_misalign)
  );

  assign pc_valid = (state_q == RUN);
  assign adv      = pc_valid & fetch_ready & ~stall;
  assign redirect = (sel_src != SRC_SEQ);
  assign pc_out   = pc_q;
  assign pc_plus4 = pc_q + PC_STEP;
  assign misalign = misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pend_v_d = pend_v_q;
    pend_t_d = pend_t_q;

    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = BOOT;
    endcase

    // A fresh redirect beats the buffered one; a non-advancing redirect
    // replaces whatever is buffered.
    if (adv) begin
      pend_v_d = 1'b0;
      pend_t_d = '0;
      if (redirect) begin
        pc_d = sel_target;
      end else if (pend_v_q) begin
        pc_d = pend_t_q;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end else if (redirect) begin
      pend_v_d = 1'b1;
      pend_t_d = sel_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_t_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_t_q   <= pend_t_d;
      misalign_q <= sel_misalign;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: expectations are queued as
// stimulus is applied and popped after the following clock edge.
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        fetch_ready;
  logic        stall;
  logic        branch_en;
  logic [15:0] branch_offset;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        jr_en;
  logic [31:0] jr_addr;
  logic [31:0] pc_out;
  logic        pc_valid;
  logic [31:0] pc_plus4;
  logic        misalign;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        valid;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int unsigned total = 0;
  int unsigned bad   = 0;

  pc_sequencer #(.RESET_PC(32'h0000_3000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_ready   (fetch_ready),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .jr_en         (jr_en),
    .jr_addr       (jr_addr),
    .pc_out        (pc_out),
    .pc_valid      (pc_valid),
    .pc_plus4      (pc_plus4),
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (observed hang, required finish)");
    $fatal(1, "watchdog");
  end

  task automatic push(input string tag, input logic [31:0] pc, input logic valid, input logic mis);
    exp_t e;
    e.tag   = tag;
    e.pc    = pc;
    e.valid = valid;
    e.mis   = mis;
    q.push_back(e);
  endtask

  task automatic compare();
    exp_t        e;
    logic [65:0] obs;
    logic [65:0] req;
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty: observed pc=%h, required a queued expectation", pc_out);
      return;
    end
    e   = q.pop_front();
    obs = {pc_out, pc_plus4, pc_valid, misalign};
    req = {e.pc, e.pc + 32'd4, e.valid, e.mis};
    assert (obs === req) else begin
      bad++;
      $error("FAIL %s: observed pc=%h plus4=%h valid=%b mis=%b, required pc=%h plus4=%h valid=%b mis=%b",
             e.tag, pc_out, pc_plus4, pc_valid, misalign, e.pc, e.pc + 32'd4, e.valid, e.mis);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the rising edge.
  task automatic tick(input string tag, input logic [31:0] pc, input logic valid, input logic mis);
    push(tag, pc, valid, mis);
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic now(input string tag, input logic [31:0] pc, input logic valid, input logic mis);
    push(tag, pc, valid, mis);
    compare();
  endtask

  initial begin
    rst_n         = 1'b0;
    fetch_ready   = 1'b1;
    stall         = 1'b0;
    branch_en     = 1'b0;
    branch_offset = '0;
    jump_en       = 1'b0;
    jump_target   = '0;
    jr_en         = 1'b0;
    jr_addr       = '0;

    #12;
    rst_n = 1'b1;
    #1;
    now ("reset",     32'h3000, 1'b0, 1'b0);
    tick("boot_run",  32'h3000, 1'b1, 1'b0);
    tick("seq_3004",  32'h3004, 1'b1, 1'b0);
    tick("seq_3008",  32'h3008, 1'b1, 1'b0);
    tick("seq_300c",  32'h300C, 1'b1, 1'b0);
    tick("seq_3010",  32'h3010, 1'b1, 1'b0);

    branch_en = 1'b1; branch_offset = 16'hFFFC;
    tick("br_back",   32'h3004, 1'b1, 1'b0);
    branch_en = 1'b0;
    tick("seq_3008b", 32'h3008, 1'b1, 1'b0);
    tick("seq_300cb", 32'h300C, 1'b1, 1'b0);
    tick("seq_3010b", 32'h3010, 1'b1, 1'b0);
    branch_en = 1'b1; branch_offset = 16'h0003;
    tick("br_fwd",    32'h3020, 1'b1, 1'b0);
    branch_en = 1'b0;

    stall = 1'b1; jump_en = 1'b1; jump_target = 32'h3400;
    tick("stall1",    32'h3020, 1'b1, 1'b0);
    jump_en = 1'b0;
    tick("stall2",    32'h3020, 1'b1, 1'b0);
    tick("stall3",    32'h3020, 1'b1, 1'b0);
    stall = 1'b0;
    tick("pend_apply",32'h3400, 1'b1, 1'b0);
    tick("after_pend",32'h3404, 1'b1, 1'b0);

    jump_en = 1'b1; jump_target = 32'h3008;
    tick("jump_3008", 32'h3008, 1'b1, 1'b0);
    jump_en = 1'b1; jump_target = 32'h0040_0000;
    jr_en   = 1'b1; jr_addr     = 32'h0000_3103;
    tick("jr_wins",   32'h3100, 1'b1, 1'b1);
    jump_en = 1'b0; jr_en = 1'b0;
    tick("mis_pulse", 32'h3104, 1'b1, 1'b0);

    jr_en = 1'b1; jr_addr = 32'hFFFF_FFFC;
    tick("jr_top",    32'hFFFF_FFFC, 1'b1, 1'b0);
    jr_en = 1'b0;
    tick("wrap",      32'h0000_0000, 1'b1, 1'b0);
    tick("wrap_seq",  32'h0000_0004, 1'b1, 1'b0);

    fetch_ready = 1'b0;
    tick("not_ready", 32'h0000_0004, 1'b1, 1'b0);
    fetch_ready = 1'b1;
    tick("ready_adv", 32'h0000_0008, 1'b1, 1'b0);

    stall = 1'b1; jump_en = 1'b1; jump_target = 32'h5000;
    tick("ovr_1",     32'h0000_0008, 1'b1, 1'b0);
    jump_target = 32'h6000;
    tick("ovr_2",     32'h0000_0008, 1'b1, 1'b0);
    stall = 1'b0; jump_en = 1'b0;
    tick("ovr_apply", 32'h6000, 1'b1, 1'b0);
    tick("ovr_seq",   32'h6004, 1'b1, 1'b0);

    stall = 1'b1; jr_en = 1'b1; jr_addr = 32'h7001;
    tick("buf_mis",   32'h6004, 1'b1, 1'b1);
    jr_en = 1'b0;
    tick("buf_hold",  32'h6004, 1'b1, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    now ("async_rst", 32'h3000, 1'b0, 1'b0);
    stall = 1'b0;
    #2;
    rst_n = 1'b1;
    #1;
    now ("rst_rel",   32'h3000, 1'b0, 1'b0);
    tick("boot_run2", 32'h3000, 1'b1, 1'b0);
    tick("no_stale",  32'h3004, 1'b1, 1'b0);
    tick("seq_after", 32'h3008, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer for the single-issue MIPS-style core. Holds the architectural PC and presents it to instruction fetch with a valid/ready handshake. Exports `pc_plus4` so the jump-address concatenation stage can take bits [31:28] as the region field, and accepts that stage's 32-bit jump address back as a redirect source. Arbitrates sequential, branch, jump and jump-register next-PC sources, with stall support and a one-entry pending-redirect buffer.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `fetch_ready`  in  1  instruction memory accepts `pc_out` this cycle.
- `stall`  in  1  pipeline hold; PC must not advance.
- `branch_en`  in  1  taken branch for the instruction at `pc_out`.
- `branch_offset`  in  16  signed word offset from the instruction.
- `jump_en`  in  1  J/JAL redirect.
- `jump_target`  in  32  `{pc_plus4[31:28], instr_index, 2'b00}` from the concatenation stage.
- `jr_en`  in  1  JR/JALR redirect.
- `jr_addr`  in  32  register-file operand.
- `pc_out`  out  32  current fetch address.
- `pc_valid`  out  1  `pc_out` is valid for fetch.
- `pc_plus4`  out  32  `pc_out + 4`, combinational.
- `misalign`  out  1  one-cycle pulse: a JR redirect had `jr_addr[1:0] != 0`.

## Operation
- FSM states: BOOT, RUN.
  - BOOT is entered on reset: `pc_valid=0`, `pc_out=RESET_PC`.
  - BOOT→RUN unconditionally on the first clock after `rst_n` deasserts.
  - RUN→RUN until the next reset.
- Advance condition: `adv = pc_valid & fetch_ready & ~stall`.
- Redirect priority: jr > jump > branch. Only the highest-priority asserted source is used.
  - JR target: `{jr_addr[31:2], 2'b00}`. Also pulses `misalign` when `jr_addr[1:0] != 0`.
  - Jump target: `jump_target` unchanged.
  - Branch target: `pc_out + 4 + (sext(branch_offset) << 2)`. Use mod-2^32 arithmetic; carries out of bit 31 are discarded.
- Next PC on `adv`, first matching rule wins:
  1. New redirect this cycle → its target.
  2. Pending valid → pending target.
  3. Otherwise → `pc_out + 4`.
- Pending buffer: 1 valid bit plus 32-bit target.
  - A redirect while `~adv` (stall, `~fetch_ready`, or BOOT) loads the buffer.
  - A newer redirect in a later non-advancing cycle overwrites it.
  - The buffer is cleared on `adv`.
- Wrap-around: `32'hFFFF_FFFC + 4 = 32'h0000_0000`. No flag is raised.
- `misalign` is generated at redirect capture time, whether applied now or buffered. It is never generated from the pending path.

## Timing
- Reset values: `pc_out=RESET_PC`, `pc_valid=0`, pending valid=0, pending target=0, `misalign=0`, state=BOOT.
- Reset asserted mid-operation clears everything asynchronously. Any pending redirect is discarded.
- `pc_out` is registered. A redirect seen with `adv=1` in cycle N appears on `pc_out` in cycle N+1. There is no extra latency.
- Redirect held through stall: captured in cycle N, applied at the first `adv` cycle M, visible in M+1.
- `pc_valid` stays 1 in RUN, including during stall. Fetch may re-sample the same address.
- `stall` and `fetch_ready=0` have the same effect: `pc_out` is held.
- Simultaneous `jr_en` and `jump_en`: JR wins, and the jump is dropped, not buffered.
- `pc_plus4` is purely combinational from `pc_out`.

## Structure
- Shared package `cpu_pkg`:
  - `RESET_PC` default.
  - `PC_STEP = 4`.
  - Redirect-source enum {SRC_SEQ, SRC_BR, SRC_J, SRC_JR}.
  - FSM state enum.
- One sub-module, `pc_target_sel`: combinational priority encoder plus branch adder. Outputs the selected source, the target, and the misalign indication.
- The top level holds the FSM, PC register and pending buffer.

## Test plan
- Reset then idle with `fetch_ready=1`:
  - Cycle after reset: `pc_valid=0`, `pc_out=0x3000`.
  - Following cycles: `pc_out` = 0x3000, 0x3004, 0x3008.
- At `pc_out=0x3010`, `branch_en=1`, offset 16'hFFFC → next `pc_out=0x3004`. At 0x3010 with offset 16'h0003 → next `pc_out=0x3020`.
- At `pc_out=0x3008`, `jump_en=1`, `jr_en=1`, `jump_target=0x0040_0000`, `jr_addr=0x0000_3103`:
  - Next `pc_out=0x3100`.
  - `misalign=1` for exactly one cycle.
- Redirect under stall:
  - `stall=1` for 3 cycles at `pc_out=0x3020`.
  - `jump_en=1` (target 0x3400) only in stall cycle 1.
  - `pc_out` holds 0x3020, then becomes 0x3400 one cycle after `stall` falls.
  - Then 0x3404.
- `pc_out=0xFFFF_FFFC`, advance → `pc_out=0x0000_0000`. Check `pc_plus4` tracks `pc_out`.
- Pending redirect buffered, then `rst_n` pulsed low mid-cycle:
  - Immediate `pc_out=0x3000`, `pc_valid=0`.
  - After release, sequence resumes at 0x3000. The buffered target is not applied.
